// File: rtl/pipelined_rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: stage count and geometry check.
// No logic or timing of its own.
// No backpressure; it holds only compile-time helpers.
package pipelined_rca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Geometry is legal only when the operand splits into whole, non-empty slices.
    function automatic bit geometry_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_slice.sv
// CHUNK-bit ripple-carry adder slice built from full-adder equations.
// Purely combinational, zero latency.
// No handshake; the enclosing pipeline decides when results are captured.
module rca_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined adder/subtractor resolving CHUNK bits per stage with a registered carry.
// Latency STAGES edges from acceptance to result; one operation per cycle.
// A stalled output freezes every stage; in_ready drops combinationally.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
        $error("pipelined_rca: WIDTH must be a positive multiple of CHUNK");
    end

    // Operand remainders are shifted down each stage so the next slice is always at bit 0.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic             carry;
        logic             a_msb;
        logic             b_msb;
        logic             vld;
    } stage_t;

    stage_t stg [STAGES];
    stage_t nxt [STAGES];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] sl_a;
        logic [CHUNK-1:0] sl_b;
        logic [CHUNK-1:0] sl_s;
        logic             sl_ci;
        logic             sl_co;

        rca_slice #(.CHUNK(CHUNK)) u_slice (
            .a  (sl_a),
            .b  (sl_b),
            .ci (sl_ci),
            .s  (sl_s),
            .co (sl_co)
        );

        if (k == 0) begin : g_first
            assign sl_a  = a[CHUNK-1:0];
            assign sl_b  = b_eff[CHUNK-1:0];
            assign sl_ci = cin_eff;
            assign nxt[k] = '{
                sum:   WIDTH'(sl_s),
                a_rem: a >> CHUNK,
                b_rem: b_eff >> CHUNK,
                carry: sl_co,
                a_msb: a[WIDTH-1],
                b_msb: b_eff[WIDTH-1],
                vld:   in_valid
            };
        end else begin : g_next
            localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);
            assign sl_a  = stg[k-1].a_rem[CHUNK-1:0];
            assign sl_b  = stg[k-1].b_rem[CHUNK-1:0];
            assign sl_ci = stg[k-1].carry;
            assign nxt[k] = '{
                sum:   (stg[k-1].sum & ~SLICE_MASK) | (WIDTH'(sl_s) << (k * CHUNK)),
                a_rem: stg[k-1].a_rem >> CHUNK,
                b_rem: stg[k-1].b_rem >> CHUNK,
                carry: sl_co,
                a_msb: stg[k-1].a_msb,
                b_msb: stg[k-1].b_msb,
                vld:   stg[k-1].vld
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= nxt[i];
            end
        end
    end

    assign out_valid = stg[STAGES-1].vld;
    assign s         = stg[STAGES-1].sum;
    assign co        = stg[STAGES-1].carry;
    assign ovf       = (stg[STAGES-1].a_msb == stg[STAGES-1].b_msb) &&
                       (stg[STAGES-1].sum[WIDTH-1] != stg[STAGES-1].a_msb);

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca: default 16/4 geometry plus a single-stage 8/8 instance.
module tb_pipelined_rca;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
    logic [15:0] a, b, s;

    logic        in_valid8, in_ready8, ci8, sub8, out_valid8, out_ready8, co8, ovf8;
    logic [7:0]  a8, b8, s8;

    int n_vec = 0;
    int n_err = 0;

    pipelined_rca #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf)
    );

    pipelined_rca #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ci(ci8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .co(co8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_q[$];
    logic [15:0] exp_front;
    int          sent, rcvd, stalls, n_ops;

    initial begin
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; ci = 0; sub = 0; out_ready = 1;
        in_valid8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0; out_ready8 = 1;
        tick();
        // Inputs presented during reset must be ignored.
        in_valid = 1; a = 16'h1234; b = 16'h1111;
        tick();
        in_valid = 0;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst8_out_valid", 32'(out_valid8), 32'd0);
        tick();
        check("rst_ignored_input", 32'(out_valid), 32'd0);

        // Carry ripples through all four slices.
        in_valid = 1; a = 16'h0001; b = 16'hFFFF; ci = 0; sub = 0;
        tick();
        in_valid = 0;
        tick();
        tick();
        check("ripple_not_early", 32'(out_valid), 32'd0);
        tick();
        check("ripple_vld", 32'(out_valid), 32'd1);
        check("ripple_s", 32'(s), 32'h0000);
        check("ripple_co", 32'(co), 32'd1);
        check("ripple_ovf", 32'(ovf), 32'd0);
        tick();
        check("ripple_single", 32'(out_valid), 32'd0);

        // Signed overflow on add, then on subtract.
        in_valid = 1; a = 16'h7FFF; b = 16'h0001; ci = 0; sub = 0;
        tick();
        a = 16'h8000; b = 16'h0001; sub = 1;
        tick();
        in_valid = 0; sub = 0;
        tick();
        tick();
        check("ovf_add_s", 32'(s), 32'h8000);
        check("ovf_add_co", 32'(co), 32'd0);
        check("ovf_add_ovf", 32'(ovf), 32'd1);
        tick();
        check("ovf_sub_vld", 32'(out_valid), 32'd1);
        check("ovf_sub_s", 32'(s), 32'h7FFF);
        check("ovf_sub_co", 32'(co), 32'd1);
        check("ovf_sub_ovf", 32'(ovf), 32'd1);
        tick();

        // Back-to-back stream: a=i, b=3i, ci=i[0] -> s = 4i + i[0].
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                in_valid = 1; a = 16'(c); b = 16'(3 * c); ci = c[0];
            end else begin
                in_valid = 0;
            end
            #1;
            check("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (c >= 3) begin
                check("stream_vld", 32'(out_valid), 32'd1);
                check("stream_s", 32'(s), 32'(4 * (c - 3) + ((c - 3) % 2)));
            end
        end
        in_valid = 0; ci = 0;
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure mid-stream: out_ready low for cycles 5..9.
        n_ops = 8; sent = 0; rcvd = 0; stalls = 0;
        for (int c = 0; c < 60 && rcvd < n_ops; c++) begin
            out_ready = !(c >= 5 && c <= 9);
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_s_stable", 32'(s), 32'(exp_q[0]));
            end
            if (out_valid && out_ready) begin
                exp_front = exp_q.pop_front();
                check("bp_s_order", 32'(s), 32'(exp_front));
                rcvd++;
            end
            if (sent < n_ops) begin
                in_valid = 1; a = 16'h0100 + 16'(sent); b = 16'(sent); ci = 0; sub = 0;
                if (in_ready) begin
                    exp_q.push_back(16'h0100 + 16'(2 * sent));
                    sent++;
                end
            end else begin
                in_valid = 0;
            end
            tick();
        end
        in_valid = 0; out_ready = 1;
        check("bp_all_received", 32'(rcvd), 32'(n_ops));
        check("bp_stall_cycles", 32'(stalls), 32'd5);
        tick();
        check("bp_no_duplicate", 32'(out_valid), 32'd0);

        // Reset with three ops in flight.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; a = 16'h1111 * 16'(c + 1); b = 16'h0001; ci = 0;
            tick();
        end
        rst = 1; a = 16'h0009;
        tick();
        rst = 0; in_valid = 0;
        check("flush_vld", 32'(out_valid), 32'd0);
        in_valid = 1; a = 16'd5; b = 16'd7;
        tick();
        in_valid = 0;
        check("flush_stale0", 32'(out_valid), 32'd0);
        tick();
        check("flush_stale1", 32'(out_valid), 32'd0);
        tick();
        check("flush_stale2", 32'(out_valid), 32'd0);
        tick();
        check("flush_next_vld", 32'(out_valid), 32'd1);
        check("flush_next_s", 32'(s), 32'd12);
        tick();
        check("flush_next_single", 32'(out_valid), 32'd0);

        // Single-stage instance: one edge of latency.
        in_valid8 = 1; a8 = 8'hF0; b8 = 8'h10; ci8 = 1; sub8 = 0;
        tick();
        in_valid8 = 0;
        check("s1_vld", 32'(out_valid8), 32'd1);
        check("s1_s", 32'(s8), 32'h01);
        check("s1_co", 32'(co8), 32'd1);
        check("s1_ovf", 32'(ovf8), 32'd0);
        out_ready8 = 0;
        #1;
        check("s1_in_ready_stall", 32'(in_ready8), 32'd0);
        tick();
        check("s1_hold_s", 32'(s8), 32'h01);
        out_ready8 = 1;
        tick();
        check("s1_drained", 32'(out_valid8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It generalises the fixed 4-bit combinational adder to arbitrary WIDTH.
- Each operand is split into CHUNK-bit slices. One slice is resolved per pipeline stage, and the carry is registered between stages.
- Valid/ready handshakes on input and output, with backpressure. Throughput is one operation per cycle.
- Sits between the operand-issue logic and the result writeback in the datapath.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, and STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, ci, sub are valid
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in; ignored when sub=1
- sub  input  1  1: compute a - b as a + ~b + 1
- out_valid  output  1  s, co, ovf are valid
- out_ready  input  1  consumer accepts the result
- s  output  WIDTH  sum / difference
- co  output  1  carry-out of the MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, s 0, co 0, ovf 0, all data and carry registers 0. in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation: every in-flight operation is discarded, with no partial output. Inputs presented while rst=1 are ignored.
- Pipeline structure: STAGES register stages. Stage k (k = 0..STAGES-1) holds:
  - the sum bits of slices 0..k;
  - the registered carry out of slice k;
  - the unprocessed slices of a and effective b;
  - the MSB operand sign bits for overflow;
  - a valid bit.
- Stage 0 is loaded at the accepting edge: slice 0 of a + b_eff + cin_eff.
- Operand conditioning:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? 1 : ci
- Stage k adds slice k of a and b_eff plus the registered carry from stage k-1. This is a CHUNK-bit ripple add with carry-out into stage k.
- Latency: an operation accepted at edge t appears on the outputs after edge t+STAGES-1. For the defaults (4 stages), it appears after edge t+3.
- Outputs are driven directly from the last stage registers:
  - s is the full assembled sum;
  - co is the final carry;
  - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
- Handshake:
  - Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
  - Global advance enable: adv = !(out_valid && !out_ready).
  - in_ready = adv, combinationally from out_valid and out_ready.
  - When adv=0, all stages hold their contents and valid bits.
  - When adv=1, every stage shifts forward. Stage 0 valid takes in_valid.
- Output stability: while out_valid=1 and out_ready=0, s, co and ovf are held stable.
- Bubbles: gaps in in_valid propagate as invalid stages. There is no compaction; bubble position is preserved.
- Simultaneous events: an input accepted and an output consumed in the same cycle is allowed and sustains full throughput.
- Data-path registers of invalid stages may hold stale data. Outputs are meaningful only when out_valid=1.
- Width rules: all addition is unsigned modulo 2^WIDTH. The carry chain is exactly WIDTH+1 bits, including cin_eff.
- STAGES=1: degenerates to a single-register adder. Latency is 1 edge, and in_ready still follows the adv rule.

Decomposition:
- Package pipelined_rca_pkg holds:
  - function/localparam for STAGES = WIDTH/CHUNK;
  - a compile-time check that WIDTH % CHUNK == 0;
  - a stage-record typedef (sum, operand remainder, carry, valid) parametrised by WIDTH.
- Sub-module rca_slice: combinational CHUNK-bit ripple adder, ports a, b, ci, s, co. It is instantiated STAGES times via generate. Each instance is built from full-adder equations matching the existing gate-level adder structure.

Test Plan:
- Defaults, a=16'h0001, b=16'hFFFF, ci=0, sub=0, out_ready=1 -> after edge t+3: s=16'h0000, co=1, ovf=0. This exercises the carry ripple across all 4 stages.
- a=16'h7FFF, b=16'h0001, sub=0 -> s=16'h8000, co=0, ovf=1. Then a=16'h8000, b=16'h0001, sub=1 -> s=16'h7FFF, co=1, ovf=1.
- Back-to-back stream of 8 ops (a=i, b=3*i, ci=i[0]) with out_ready=1 -> 8 consecutive out_valid cycles in order; s = 4*i + i[0]; in_ready constantly 1.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during those cycles; s stable; no results dropped or duplicated; order preserved after release.
- Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 from the following cycle; the next accepted op (a=5, b=7) gives s=12 after 3 further edges; no stale results.
- WIDTH=8, CHUNK=8 (STAGES=1), a=8'hF0, b=8'h10, ci=1 -> after 1 edge: s=8'h01, co=1.
